pe_conf_seq: RTL and testbench
==============================

PE_CONF_SEQ -- requirements
Module: pe_conf_seq

Interface
REQ-001 Parameters SHALL be NUM_PE, default 4, number of PEs driven; NUM_CTX, default 8, contexts stored; CONF_W, default 8, per-PE conf word width.
REQ-002 clk  input  1  rising-edge clock; the block SHALL use this single clock.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 cfg_valid  input  1  configuration write request.
REQ-005 cfg_ready  output  1  the block can accept a configuration write.
REQ-006 cfg_ctx  input  log2(NUM_CTX)  target context index.
REQ-007 cfg_pe  input  log2(NUM_PE)  target PE index.
REQ-008 cfg_conf  input  CONF_W  conf word to store.
REQ-009 start  input  1  single-cycle run request.
REQ-010 abort  input  1  stop a run immediately.
REQ-011 ctx_last  input  log2(NUM_CTX)  index of the last context in a loop body, sampled at start.
REQ-012 iter_count  input  8  loop iterations, sampled at start; 0 is treated as 1.
REQ-013 branch_in  input  1  OR of PE branch_out bits; requests early loop exit.
REQ-014 conf_out  output  NUM_PE*CONF_W  per-PE conf words; PE i uses bits [i*CONF_W +: CONF_W].
REQ-015 pe_en  output  1  PE enable.
REQ-016 busy  output  1  high while in RUN.
REQ-017 done  output  1  one-cycle pulse at normal or early completion.

Function
REQ-018 The FSM SHALL have the states IDLE, RUN and FIN.
REQ-019 IDLE behaviour:
- cfg_ready SHALL be 1.
- A write SHALL occur when cfg_valid and cfg_ready are both 1.
- Each write SHALL store cfg_conf into lane cfg_pe of context cfg_ctx; all other lanes SHALL be unchanged.
REQ-020 cfg_ready SHALL be 0 in RUN and in FIN; cfg_valid SHALL be ignored in those states.
REQ-021 start in IDLE SHALL move the FSM to RUN at the next edge.
- The same edge SHALL latch ctx_last and iter_count.
- The same edge SHALL clear the context pointer ctx and the iteration counter it.
REQ-022 If a write and start occur in the same IDLE cycle, the write SHALL complete and be visible in the first RUN cycle.
REQ-023 In every RUN cycle:
- conf_out SHALL equal the stored context ctx.
- pe_en SHALL be 1.
- busy SHALL be 1.
REQ-024 In RUN with ctx < ctx_last, ctx SHALL increment by 1.
REQ-025 In RUN with ctx == ctx_last:
- If (it+1 >= max(iter_count,1)) or branch_in=1, the FSM SHALL go to FIN.
- Otherwise ctx SHALL return to 0 and it SHALL increment.
REQ-026 branch_in SHALL be ignored in RUN when ctx != ctx_last.
REQ-027 The context count SHALL be ctx_last+1; ctx_last=0 SHALL repeat context 0 every cycle.
REQ-028 In FIN, done SHALL be 1 for exactly one cycle, conf_out SHALL be 0, pe_en and busy SHALL be 0, and the next state SHALL be IDLE.
REQ-029 abort in RUN SHALL go directly to IDLE at the next edge without a done pulse; abort in IDLE or FIN SHALL be ignored.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 Outside RUN, conf_out SHALL be all-zero and pe_en SHALL be 0.
REQ-032 Output timing:
- conf_out, pe_en, busy and done SHALL be registered.
- Latency from start to the first pe_en=1 SHALL be 1 cycle.
- A run SHALL last (ctx_last+1)*iterations cycles.

Reset
REQ-033 rst=0 SHALL asynchronously force the FSM to IDLE, set ctx and it to 0, and set conf_out to 0, pe_en, busy and done to 0, and cfg_ready to 1.
REQ-034 Context memory contents SHALL be undefined after power-up and SHALL persist across rst.
REQ-035 Reset asserted mid-run SHALL end the run with no done pulse.

Structure
REQ-036 Package pe_conf_pkg SHALL hold the state enum, the default constants for NUM_PE, NUM_CTX and CONF_W, and the NOP conf value 0.
REQ-037 Context storage SHALL be one sub-module, ctx_mem: NUM_CTX x NUM_PE*CONF_W, per-lane write enable, combinational read.

Verification
REQ-038 Write ctx0 = {0x11,0x22,0x33,0x44} and ctx1 = {0x55,..}; start with ctx_last=1, iter_count=3 -> conf_out alternates ctx0/ctx1 for 6 cycles, then done pulses once.
REQ-039 Write lane 2 of ctx0 only -> the other lanes keep their prior values.
REQ-040 Same setup as REQ-038 with branch_in=1 during the first ctx=1 cycle -> FIN after 2 RUN cycles, done=1.
REQ-041 abort in the 3rd RUN cycle -> IDLE next cycle, done never 1, conf_out=0.
REQ-042 iter_count=0, ctx_last=0 -> exactly 1 RUN cycle; in a separate test, start and cfg_valid in the same cycle -> the new word appears in the first RUN cycle.
REQ-043 Assert rst mid-run -> outputs are zero immediately; after rst release and a new start, the previously written contexts replay unchanged.

Source files
------------

// File: rtl/pe_conf_pkg.sv
// Shared types and constants for the PE configuration sequencer.
package pe_conf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int DEF_NUM_PE  = 4;
  localparam int DEF_NUM_CTX = 8;
  localparam int DEF_CONF_W  = 8;

  // Conf word driven to every PE when the array is not running.
  localparam int NOP_CONF = 0;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_conf_seq_if.sv
// Configuration write channel: valid/ready handshake plus target and data.
interface pe_conf_seq_if
  import pe_conf_pkg::*;
#(
  parameter int NUM_PE  = DEF_NUM_PE,
  parameter int NUM_CTX = DEF_NUM_CTX,
  parameter int CONF_W  = DEF_CONF_W
) ();

  localparam int CTX_W = idx_w(NUM_CTX);
  localparam int PE_W  = idx_w(NUM_PE);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CTX_W-1:0]  cfg_ctx;
  logic [PE_W-1:0]   cfg_pe;
  logic [CONF_W-1:0] cfg_conf;

  modport master (
    output cfg_valid, cfg_ctx, cfg_pe, cfg_conf,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ctx, cfg_pe, cfg_conf,
    output cfg_ready
  );

endinterface

// File: rtl/pe_conf_seq_ctx_mem.sv
// Context store: NUM_CTX entries of NUM_PE lanes, per-lane write, async read.
// No reset on the array so contents survive a sequencer reset.
module ctx_mem
  import pe_conf_pkg::*;
#(
  parameter int NUM_PE  = DEF_NUM_PE,
  parameter int NUM_CTX = DEF_NUM_CTX,
  parameter int CONF_W  = DEF_CONF_W,
  localparam int CTX_W  = idx_w(NUM_CTX)
) (
  input  logic                     clk,
  input  logic [NUM_PE-1:0]        we_i,
  input  logic [CTX_W-1:0]         wr_ctx_i,
  input  logic [CONF_W-1:0]        wr_data_i,
  input  logic [CTX_W-1:0]         rd_ctx_i,
  output logic [NUM_PE*CONF_W-1:0] rd_data_o
);

  for (genvar l = 0; l < NUM_PE; l++) begin : g_lane
    logic [CONF_W-1:0] mem_q [NUM_CTX];

    // Lane write: only the addressed lane of the addressed context changes.
    always_ff @(posedge clk) begin
      if (we_i[l]) mem_q[wr_ctx_i] <= wr_data_i;
    end

    assign rd_data_o[l*CONF_W +: CONF_W] = mem_q[rd_ctx_i];
  end

endmodule

// File: rtl/pe_conf_seq.sv
// PE configuration sequencer: stores contexts, then replays contexts
// 0..ctx_last for a number of iterations with optional early exit.
module pe_conf_seq
  import pe_conf_pkg::*;
#(
  parameter int NUM_PE  = DEF_NUM_PE,
  parameter int NUM_CTX = DEF_NUM_CTX,
  parameter int CONF_W  = DEF_CONF_W,
  localparam int CTX_W  = idx_w(NUM_CTX),
  localparam int PE_W   = idx_w(NUM_PE)
) (
  input  logic                     clk,
  input  logic                     rst,
  pe_conf_seq_if.slave             cfg,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CTX_W-1:0]         ctx_last,
  input  logic [7:0]               iter_count,
  input  logic                     branch_in,
  output logic [NUM_PE*CONF_W-1:0] conf_out,
  output logic                     pe_en,
  output logic                     busy,
  output logic                     done
);

  state_e             state_q, state_d;
  logic [CTX_W-1:0]   ctx_q, ctx_d;
  logic [CTX_W-1:0]   last_q, last_d;
  logic [7:0]         it_q, it_d;
  logic [7:0]         iter_q, iter_d;
  logic [7:0]         eff_iter;
  logic               last_iter;
  logic               cfg_wr;
  logic [NUM_PE-1:0]  lane_we;
  logic [NUM_PE*CONF_W-1:0] rd_data, conf_nxt;
  logic [NUM_PE*CONF_W-1:0] conf_out_q;
  logic               pe_en_q, busy_q, done_q;

  assign cfg.cfg_ready = (state_q == ST_IDLE);
  assign cfg_wr        = cfg.cfg_valid && cfg.cfg_ready;

  // iter_count of 0 behaves as a single iteration.
  assign eff_iter  = (iter_q == 8'd0) ? 8'd1 : iter_q;
  assign last_iter = ({1'b0, it_q} + 9'd1) >= {1'b0, eff_iter};

  // Next-state, context pointer and iteration counter.
  always_comb begin
    state_d = state_q;
    ctx_d   = ctx_q;
    it_d    = it_q;
    last_d  = last_q;
    iter_d  = iter_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          ctx_d   = '0;
          it_d    = '0;
          last_d  = ctx_last;
          iter_d  = iter_count;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          ctx_d   = '0;
          it_d    = '0;
        end else if (ctx_q < last_q) begin
          ctx_d = ctx_q + 1'b1;
        end else if (last_iter || branch_in) begin
          state_d = ST_FIN;
        end else begin
          ctx_d = '0;
          it_d  = it_q + 8'd1;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        ctx_d   = '0;
        it_d    = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ctx_q   <= '0;
      it_q    <= '0;
      last_q  <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      ctx_q   <= ctx_d;
      it_q    <= it_d;
      last_q  <= last_d;
      iter_q  <= iter_d;
    end
  end

  for (genvar l = 0; l < NUM_PE; l++) begin : g_we
    assign lane_we[l] = cfg_wr && (cfg.cfg_pe == PE_W'(l));
  end

  ctx_mem #(
    .NUM_PE  (NUM_PE),
    .NUM_CTX (NUM_CTX),
    .CONF_W  (CONF_W)
  ) u_ctx_mem (
    .clk       (clk),
    .we_i      (lane_we),
    .wr_ctx_i  (cfg.cfg_ctx),
    .wr_data_i (cfg.cfg_conf),
    .rd_ctx_i  (ctx_d),
    .rd_data_o (rd_data)
  );

  // Outputs are registered from the next context, so a write landing on the
  // same edge as start must be forwarded around the memory.
  for (genvar l = 0; l < NUM_PE; l++) begin : g_fwd
    assign conf_nxt[l*CONF_W +: CONF_W] =
      (lane_we[l] && (cfg.cfg_ctx == ctx_d)) ? cfg.cfg_conf
                                            : rd_data[l*CONF_W +: CONF_W];
  end

  // Registered PE-facing outputs; NOP conf and disabled outside RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conf_out_q <= {NUM_PE{CONF_W'(NOP_CONF)}};
      pe_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      conf_out_q <= (state_d == ST_RUN) ? conf_nxt : {NUM_PE{CONF_W'(NOP_CONF)}};
      pe_en_q    <= (state_d == ST_RUN);
      busy_q     <= (state_d == ST_RUN);
      done_q     <= (state_d == ST_FIN);
    end
  end

  assign conf_out = conf_out_q;
  assign pe_en    = pe_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pe_conf_seq.sv
// Directed bench for pe_conf_seq with hand-computed expected conf words.
module tb_pe_conf_seq;

  localparam int NUM_PE  = 4;
  localparam int NUM_CTX = 8;
  localparam int CONF_W  = 8;

  localparam logic [31:0] C0  = 32'h11223344;
  localparam logic [31:0] C1  = 32'h55667788;
  localparam logic [31:0] C0L = 32'h11AB3344;
  localparam logic [31:0] C0F = 32'h11223399;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, branch_in = 1'b0;
  logic [2:0]  ctx_last = '0;
  logic [7:0]  iter_count = '0;
  logic [31:0] conf_out;
  logic        pe_en, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  pe_conf_seq_if #(.NUM_PE(NUM_PE), .NUM_CTX(NUM_CTX), .CONF_W(CONF_W)) cfg_if ();

  pe_conf_seq #(.NUM_PE(NUM_PE), .NUM_CTX(NUM_CTX), .CONF_W(CONF_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg        (cfg_if.slave),
    .start      (start),
    .abort      (abort),
    .ctx_last   (ctx_last),
    .iter_count (iter_count),
    .branch_in  (branch_in),
    .conf_out   (conf_out),
    .pe_en      (pe_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] c, input logic [1:0] p, input logic [7:0] v);
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ctx = c; cfg_if.cfg_pe = p; cfg_if.cfg_conf = v;
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  // Pulse start; returns positioned in the first RUN cycle.
  task automatic go(input logic [2:0] last, input logic [7:0] iters);
    start = 1'b1; ctx_last = last; iter_count = iters;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_assert++;
    if (conf_out !== 32'h0 || pe_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state conf=%h en=%b busy=%b done=%b rdy=%b exp 0/0/0/0/1", conf_out, pe_en, busy, done, cfg_if.cfg_ready);
    end
    step(); step();
    rst = 1'b1;
    step();
    n_assert++;
    if (busy !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_idle busy=%b rdy=%b exp 0/1", busy, cfg_if.cfg_ready);
    end
  endtask

  task automatic load_contexts();
    wr(3'd0, 2'd0, 8'h44); wr(3'd0, 2'd1, 8'h33); wr(3'd0, 2'd2, 8'h22); wr(3'd0, 2'd3, 8'h11);
    wr(3'd1, 2'd0, 8'h88); wr(3'd1, 2'd1, 8'h77); wr(3'd1, 2'd2, 8'h66); wr(3'd1, 2'd3, 8'h55);
  endtask

  // Six alternating cycles then a single done pulse; start mid-run is ignored.
  task automatic test_run(input string tag);
    go(3'd1, 8'd3);
    for (int k = 0; k < 6; k++) begin
      n_assert++;
      if (conf_out !== ((k % 2) ? C1 : C0) || pe_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_cycle%0d conf=%h en=%b busy=%b done=%b exp %h/1/1/0", tag, k, conf_out, pe_en, busy, done, (k % 2) ? C1 : C0);
      end
      start = (k == 2);
      step();
    end
    start = 1'b0;
    n_assert++;
    if (done !== 1'b1 || conf_out !== 32'h0 || pe_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_fin conf=%h en=%b busy=%b done=%b exp 0/0/0/1", tag, conf_out, pe_en, busy, done);
    end
    step();
    n_assert++;
    if (done !== 1'b0 || busy !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_idle done=%b busy=%b rdy=%b exp 0/0/1", tag, done, busy, cfg_if.cfg_ready);
    end
  endtask

  task automatic test_lane_write();
    wr(3'd0, 2'd2, 8'hAB);
    go(3'd1, 8'd1);
    n_assert++;
    if (conf_out !== C0L) begin
      n_fail++; $display("FAIL lane_ctx0 conf=%h exp %h", conf_out, C0L);
    end
    step();
    n_assert++;
    if (conf_out !== C1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL lane_ctx1 conf=%h busy=%b exp %h/1", conf_out, busy, C1);
    end
    step();
    n_assert++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL lane_done done=%b exp 1", done);
    end
    step();
    wr(3'd0, 2'd2, 8'h22);
  endtask

  // branch_in held high from the first cycle: ignored at ctx0, taken at ctx1.
  // A config write attempted mid-run must be refused and have no effect.
  task automatic test_branch();
    go(3'd1, 8'd3);
    branch_in = 1'b1;
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ctx = 3'd1; cfg_if.cfg_pe = 2'd0; cfg_if.cfg_conf = 8'hEE;
    n_assert++;
    if (conf_out !== C0 || cfg_if.cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL branch_c1 conf=%h rdy=%b exp %h/0", conf_out, cfg_if.cfg_ready, C0);
    end
    step();
    n_assert++;
    if (conf_out !== C1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL branch_c2 conf=%h busy=%b exp %h/1", conf_out, busy, C1);
    end
    step();
    branch_in = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    n_assert++;
    if (done !== 1'b1 || busy !== 1'b0 || conf_out !== 32'h0) begin
      n_fail++; $display("FAIL branch_fin done=%b busy=%b conf=%h exp 1/0/0", done, busy, conf_out);
    end
    step();
  endtask

  task automatic test_abort();
    int seen_done = 0;
    go(3'd1, 8'd3);
    step(); step();
    n_assert++;
    if (conf_out !== C0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_c3 conf=%h busy=%b exp %h/1", conf_out, busy, C0);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_assert++;
    if (busy !== 1'b0 || pe_en !== 1'b0 || conf_out !== 32'h0 || cfg_if.cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_idle busy=%b en=%b conf=%h rdy=%b exp 0/0/0/1", busy, pe_en, conf_out, cfg_if.cfg_ready);
    end
    for (int k = 0; k < 3; k++) begin
      if (done === 1'b1) seen_done++;
      step();
    end
    if (done === 1'b1) seen_done++;
    n_assert++;
    if (seen_done !== 0) begin
      n_fail++; $display("FAIL abort_no_done count=%0d exp 0", seen_done);
    end
  endtask

  task automatic test_single();
    go(3'd0, 8'd0);
    n_assert++;
    if (conf_out !== C0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_run conf=%h busy=%b exp %h/1", conf_out, busy, C0);
    end
    step();
    n_assert++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_fin done=%b busy=%b exp 1/0", done, busy);
    end
    step();
  endtask

  task automatic test_same_cycle();
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_ctx = 3'd0; cfg_if.cfg_pe = 2'd0; cfg_if.cfg_conf = 8'h99;
    go(3'd0, 8'd1);
    cfg_if.cfg_valid = 1'b0;
    n_assert++;
    if (conf_out !== C0F) begin
      n_fail++; $display("FAIL same_cycle_fwd conf=%h exp %h", conf_out, C0F);
    end
    step(); step();
    wr(3'd0, 2'd0, 8'h44);
  endtask

  task automatic test_reset_midrun();
    go(3'd1, 8'd3);
    step();
    rst = 1'b0;
    #1;
    n_assert++;
    if (conf_out !== 32'h0 || pe_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrun_reset conf=%h en=%b busy=%b done=%b rdy=%b exp 0/0/0/0/1", conf_out, pe_en, busy, done, cfg_if.cfg_ready);
    end
    step();
    rst = 1'b1;
    step();
    n_assert++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrun_no_done done=%b busy=%b exp 0/0", done, busy);
    end
    test_run("replay");
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ctx = '0; cfg_if.cfg_pe = '0; cfg_if.cfg_conf = '0;
    test_reset();
    load_contexts();
    test_run("run");
    test_lane_write();
    test_branch();
    test_run("after_branch");
    test_abort();
    test_single();
    test_same_cycle();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
